// File: rtl/rv32_mem_pkg.sv
// rtl/rv32_mem_pkg.sv - shared RV32I memory-access constants and LSU state type
package rv32_mem_pkg;

    localparam int WORD_IDX_W = 5;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_MERGE = 1'b1
    } lsu_state_e;

endpackage

// File: rtl/lsu_subword_if.sv
// rtl/lsu_subword_if.sv - core-side request and memory-side bus of the subword LSU
interface lsu_subword_if #(
    parameter int WORD_IDX_W = rv32_mem_pkg::WORD_IDX_W
);
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic [31:0] load_data;
    logic        acc_err;
    logic        err_sticky;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    // Index bits the memory actually decodes; upper word-address bits are ignored.
    logic [WORD_IDX_W-1:0] mem_idx;
    assign mem_idx = mem_addr[WORD_IDX_W-1:0];

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
        output stall, load_data, acc_err, err_sticky, mem_we, mem_addr, mem_wd
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
        input  stall, load_data, acc_err, err_sticky, mem_we, mem_addr, mem_wd, mem_idx
    );
endinterface

// File: rtl/lsu_lane_extract.sv
// rtl/lsu_lane_extract.sv - byte/half/word selection with sign or zero extension for loads
module lsu_lane_extract
    import rv32_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = word[{lane, 3'b000} +: 8];
        half_v = word[{lane[1], 4'b0000} +: 16];
        case (funct3)
            F3_B:    data = {{24{byte_v[7]}}, byte_v};
            F3_BU:   data = {24'h000000, byte_v};
            F3_H:    data = {{16{half_v[15]}}, half_v};
            F3_HU:   data = {16'h0000, half_v};
            F3_W:    data = word;
            default: data = 32'h0000_0000;
        endcase
    end
endmodule

// File: rtl/lsu_subword.sv
// rtl/lsu_subword.sv - RV32I load/store unit in front of a word-addressed memory, RMW for SB/SH
module lsu_subword
    import rv32_mem_pkg::*;
(
    input logic         CLK,
    input logic         RST,
    lsu_subword_if.slave bus
);
    lsu_state_e  state_q, state_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] merged;
    logic [31:0] extracted;
    logic        err_sticky_q;
    logic        is_b, is_h, is_w;
    logic        legal, misaligned, in_idle, access_ok;

    always_comb begin
        is_b       = (bus.req_funct3 == F3_B) || (bus.req_funct3 == F3_BU);
        is_h       = (bus.req_funct3 == F3_H) || (bus.req_funct3 == F3_HU);
        is_w       = (bus.req_funct3 == F3_W);
        // Unsigned variants exist only for loads.
        legal      = bus.req_we ? (bus.req_funct3 == F3_B || bus.req_funct3 == F3_H || is_w)
                                : (is_b || is_h || is_w);
        misaligned = (is_w && bus.req_addr[1:0] != 2'b00) || (is_h && bus.req_addr[0]);
    end

    assign in_idle     = (state_q == ST_IDLE);
    assign access_ok   = bus.req_valid && in_idle && legal && !misaligned;
    assign bus.acc_err = bus.req_valid && in_idle && (!legal || misaligned);

    lsu_lane_extract u_extract (
        .word   (bus.mem_rd),
        .lane   (bus.req_addr[1:0]),
        .funct3 (bus.req_funct3),
        .data   (extracted)
    );

    assign bus.load_data  = (access_ok && !bus.req_we) ? extracted : 32'h0000_0000;
    assign bus.mem_addr   = {2'b00, bus.req_addr[31:2]};
    assign bus.err_sticky = err_sticky_q;

    // Read word with the store lane(s) overwritten; captured in the first RMW cycle.
    always_comb begin
        merged = bus.mem_rd;
        if (is_h) begin
            merged[{bus.req_addr[1], 4'b0000} +: 16] = bus.req_wdata[15:0];
        end else begin
            merged[{bus.req_addr[1:0], 3'b000} +: 8] = bus.req_wdata[7:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        merge_d    = merge_q;
        bus.mem_we = 1'b0;
        bus.stall  = 1'b0;
        bus.mem_wd = bus.req_wdata;
        case (state_q)
            ST_IDLE: begin
                if (access_ok && bus.req_we) begin
                    if (is_w) begin
                        bus.mem_we = 1'b1;
                    end else begin
                        bus.stall = 1'b1;
                        merge_d   = merged;
                        state_d   = ST_MERGE;
                    end
                end
            end
            ST_MERGE: begin
                bus.mem_we = 1'b1;
                bus.mem_wd = merge_q;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (!RST) begin
            bus.mem_we = 1'b0;
            bus.stall  = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q      <= ST_IDLE;
            merge_q      <= 32'h0000_0000;
            err_sticky_q <= 1'b0;
        end else begin
            state_q <= state_d;
            merge_q <= merge_d;
            if (bus.acc_err) begin
                err_sticky_q <= 1'b1;
            end
        end
    end
endmodule
